// File: rtl/nic_uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and receiver states.
package nic_uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_byte_rx_if.sv
// Serial input and byte/status outputs of the UART byte receiver.
interface uart_byte_rx_if;
    import nic_uart_pkg::*;

    logic                      rx_line;
    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      rx_byte_valid;
    logic                      rx_frame_err;
    logic                      rx_busy;

    modport master (
        input  rx_line,
        output rx_byte,
        output rx_byte_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        output rx_line,
        input  rx_byte,
        input  rx_byte_valid,
        input  rx_frame_err,
        input  rx_busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: samples mid-bit, emits byte/valid and frame-error pulses.
module uart_byte_rx
    import nic_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           reset,
    uart_byte_rx_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_STOP  = STOP;
    localparam logic [2:0] S_BRK   = BRK_WAIT;

    logic                      w_rx_s;
    logic                      w_cnt_last;
    logic                      w_cnt_half;
    logic [2:0]                r_state;
    logic [CW-1:0]             r_bit_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_byte;
    logic                      r_valid;
    logic                      r_ferr;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (bus.rx_line),
        .o_q   (w_rx_s)
    );

    assign w_cnt_last = (r_bit_cnt == CNT_LAST);
    assign w_cnt_half = (r_bit_cnt == CNT_HALF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state   <= S_START;
                        r_bit_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_cnt_half) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        // A start bit gone high by mid-bit is line noise
                        r_state   <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_cnt_last) begin
                        r_bit_cnt          <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        r_bit_idx          <= r_bit_idx + 1'b1;
                        if (r_bit_idx == IDX_LAST) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_cnt_last) begin
                        r_bit_cnt <= '0;
                        if (w_rx_s) begin
                            r_byte  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BRK;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_BRK: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_byte       = r_byte;
    assign bus.rx_byte_valid = r_valid;
    assign bus.rx_frame_err  = r_ferr;
    assign bus.rx_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: directed and random frames against an event-queue model.
module tb_uart_byte_rx;
    import nic_uart_pkg::*;

    localparam int C = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    uart_byte_rx_if bus ();

    uart_byte_rx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Expected pulse stream: 1 = good byte, 0 = framing error
    bit         exp_ok[$];
    logic [7:0] exp_dat[$];
    int         rd_idx         = 0;
    logic [7:0] model_byte     = 8'h00;
    int         cyc            = 0;
    int         last_valid_cyc = 0;
    int         fall_cyc       = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            model_byte = 8'h00;
        end else if (bus.rx_byte_valid || bus.rx_frame_err) begin
            check_eq("one_pulse_kind",
                     32'(bus.rx_byte_valid & bus.rx_frame_err), 32'd0);
            if (rd_idx >= exp_ok.size()) begin
                check_eq("spurious_pulse", 32'(rd_idx + 1), 32'(exp_ok.size()));
            end else begin
                check_eq("pulse_kind", 32'(bus.rx_byte_valid), 32'(exp_ok[rd_idx]));
                if (exp_ok[rd_idx]) begin
                    check_eq("rx_byte", 32'(bus.rx_byte), 32'(exp_dat[rd_idx]));
                    model_byte     = exp_dat[rd_idx];
                    last_valid_cyc = cyc;
                end else begin
                    check_eq("byte_kept_on_err", 32'(bus.rx_byte), 32'(model_byte));
                end
                rd_idx++;
            end
        end else if (bus.rx_byte !== model_byte) begin
            check_eq("byte_hold", 32'(bus.rx_byte), 32'(model_byte));
        end
    end

    task automatic drive_bit(input logic v);
        bus.rx_line = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        bus.rx_line = 1'b1;
        if (n > 0) begin
            repeat (n * C) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                              input int gap_bits);
        exp_ok.push_back(stop_ok);
        exp_dat.push_back(b);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        idle_bits(gap_bits);
    endtask

    task automatic drain(input string tag);
        repeat (3 * C) @(posedge clk);
        @(negedge clk);
        check_eq(tag, 32'(rd_idx), 32'(exp_ok.size()));
        check_eq("busy_idle", 32'(bus.rx_busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        int         gap;
        int         lat;
        bit         seen;

        bus.rx_line = 1'b1;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_byte",  32'(bus.rx_byte), 32'd0);
        check_eq("rst_valid", 32'(bus.rx_byte_valid), 32'd0);
        check_eq("rst_ferr",  32'(bus.rx_frame_err), 32'd0);
        check_eq("rst_busy",  32'(bus.rx_busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_bits(2);

        send_frame(8'hA5, 1'b1, 2);
        lat = last_valid_cyc - fall_cyc;
        check_eq("latency_in_window", 32'(lat >= 153 && lat <= 156), 32'd1);
        drain("drain_a5");

        send_frame(8'h3C, 1'b0, 2);
        drain("drain_bad_stop");

        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 2);
        drain("drain_b2b");

        bus.rx_line = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rx_line = 1'b1;
        seen = 1'b0;
        repeat (3 * C) begin
            @(negedge clk);
            if (bus.rx_busy) seen = 1'b1;
        end
        check_eq("glitch_busy", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        drain("drain_glitch");

        exp_ok.push_back(1'b0);
        exp_dat.push_back(8'h00);
        bus.rx_line = 1'b0;
        repeat (20 * C) @(posedge clk);
        #1;
        idle_bits(2);
        send_frame(8'h55, 1'b1, 2);
        drain("drain_break");

        b = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        bus.rx_line = b[4];
        repeat (C / 2) @(posedge clk);
        #1;
        reset       = 1'b1;
        bus.rx_line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_byte",  32'(bus.rx_byte), 32'd0);
        check_eq("mid_rst_valid", 32'(bus.rx_byte_valid), 32'd0);
        check_eq("mid_rst_ferr",  32'(bus.rx_frame_err), 32'd0);
        check_eq("mid_rst_busy",  32'(bus.rx_busy), 32'd0);
        @(posedge clk);
        #1;
        idle_bits(2);
        send_frame(8'h7E, 1'b1, 2);
        drain("drain_after_rst");

        for (int n = 0; n < 40; n++) begin
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 5) != 0);
            // A bad stop parks the receiver until the line idles high
            gap = ok ? int'($urandom_range(0, 2)) : 2;
            send_frame(b, ok, gap);
        end
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Single-clock 8N1 UART receiver on the HPS serial line. Sits directly upstream of the TX framer.
- Turns the asynchronous UART_RX bit stream into byte/valid pulses that the framer packs into outgoing nibbles.
- Mirrors uart_tx on the display path and runs on the same clock domain as the framer.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range is >= 4.
- DATA_BITS, 8, data bits per frame. Fixed at 8; sourced from the package.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_line  input  1  asynchronous UART input; idle high
- rx_byte  output  8  last correctly received byte; LSB is the first data bit on the wire
- rx_byte_valid  output  1  one-cycle pulse; rx_byte is new in that cycle
- rx_frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- rx_busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high.
  - Reset values: rx_byte=0x00, rx_byte_valid=0, rx_frame_err=0, rx_busy=0, state=IDLE, shift register=0, counters=0.
  - Both synchroniser flops reset to 1.
- Input synchronisation
  - rx_line passes through a 2-flop synchroniser to give rx_s.
  - All decisions use rx_s only.
- Counters
  - bit_cnt is $clog2(CLKS_PER_BIT) bits wide.
  - bit_idx is 3 bits wide.
- States
  - IDLE: when rx_s==0, go to START with bit_cnt=0.
  - START: count until bit_cnt==(CLKS_PER_BIT-1)/2 (mid start bit).
    - If rx_s==0 there, go to DATA with bit_cnt=0, bit_idx=0.
    - Otherwise treat it as a glitch and return to IDLE with no outputs.
  - DATA: when bit_cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] and clear bit_cnt.
    - Bits arrive LSB first.
    - After bit_idx==7 is sampled, go to STOP.
  - STOP: when bit_cnt==CLKS_PER_BIT-1, sample rx_s (mid stop bit).
    - If 1: rx_byte<=shift, pulse rx_byte_valid next cycle, go to IDLE.
    - If 0: pulse rx_frame_err, leave rx_byte unchanged, go to BRK_WAIT.
  - BRK_WAIT: stay until rx_s==1, then go to IDLE. This prevents a held-low line (break) from re-triggering frames.
- Timing
  - Going to IDLE at mid stop bit leaves half a bit of margin, so back-to-back frames with zero idle gap are received.
  - Latency: rx_byte_valid rises 2 (sync) + 1 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles (±1) after the falling start edge at rx_line.
- Output rules
  - rx_byte_valid and rx_frame_err are never high in the same cycle.
  - Each pulse is exactly one cycle wide.
  - rx_byte holds its value between valid pulses.
- Downstream flow control
  - There is no back-pressure. The consumer must accept every pulse; at most one byte is produced per 10 bit times.
- Reset mid-frame
  - The partial byte is discarded and no pulse is emitted.
  - The next cycle is in IDLE with outputs at their reset values.

Decomposition:
- Package nic_uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BRK_WAIT)
  - UART_DATA_BITS=8
  - UART_DEFAULT_CLKS_PER_BIT=434
- Sub-module sync_2ff (1-bit, reset value parameter) for the input synchroniser, reusable by other CDC inputs.

Test Plan:
- All scenarios use CLKS_PER_BIT=16.
- Send 0xA5 in 8N1 -> exactly one rx_byte_valid pulse with rx_byte=0xA5; rx_frame_err stays 0; rx_busy returns to 0.
- Send 0x00 then 0xFF back-to-back, with the next start bit immediately after the stop bit -> two valid pulses: 0x00 then 0xFF.
- Pull rx_line low for 4 cycles, then high -> no pulses; rx_busy asserts briefly then returns to 0.
- Send data 0x3C with the stop bit driven 0 -> one rx_frame_err pulse, no valid pulse, rx_byte still 0xA5.
- Hold rx_line low for 20 bit times, release, then send 0x55 -> exactly one rx_frame_err pulse, then one valid pulse with 0x55.
- Assert reset during data bit 4 of 0x81, release, then send 0x7E -> no pulse for 0x81; outputs are 0 after reset; a single valid pulse with 0x7E follows.
